param_arith_seq: RTL and testbench

Parametrised, handshaked successor to the team's small fixed-width registered arithmetic block.
- Accepts two W-bit unsigned operands and a 2-bit opcode on a start pulse.
- Performs add, subtract, shift-add multiply (multi-cycle) or accumulate.
- Returns a 2W-bit registered result with a one-cycle done pulse.
- Sits between the operand-select logic and the result/flag register bank of the datapath exercises.

---
 rtl/arith_pkg.sv | 15 +
 rtl/seq_mul_core.sv | 44 ++++
 rtl/param_arith_seq.sv | 149 ++++++++++++++
 tb/tb_param_arith_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared opcodes and controller state encoding for param_arith_seq.
package arith_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ACC = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_mul_core.sv
// W-cycle shift-add multiplier, LSB of the multiplier first, down-counter terminal count.
module seq_mul_core #(
   parameter int W = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic [2*W-1:0] product,
   output logic           mul_done
);

   localparam int CW = $clog2(W + 1);

   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] partial;
   logic [CW-1:0]  cnt;

   // product includes the bit being consumed this cycle, so it is final on the terminal-count edge
   assign product  = partial + (mplier[0] ? mcand : '0);
   assign mul_done = (cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         mcand   <= '0;
         mplier  <= '0;
         partial <= '0;
         cnt     <= '0;
      end else if (load) begin
         mcand   <= {{W{1'b0}}, A};
         mplier  <= B;
         partial <= '0;
         cnt     <= CW'(W);
      end else if (cnt != '0) begin
         partial <= product;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         cnt     <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/param_arith_seq.sv
// Handshaked add/sub/multiply/accumulate block with 2W-bit registered result.
// Define ARITH_SAT_EN for a saturating accumulator and the sticky ovf port.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// EXEC  | single-cycle ADD/SUB/ACC completes on next edge
// MUL   | shift-add multiply in progress in seq_mul_core
module param_arith_seq
   import arith_pkg::*;
#(
   parameter int W = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [1:0]     op,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] Y,
   output logic           neg
`ifdef ARITH_SAT_EN
   ,
   output logic           ovf
`endif
);

   state_t         state, state_nxt;
   logic           take, finish, mul_load, mul_done;
   logic [W-1:0]   a_r, b_r;
   logic [1:0]     op_r;
   logic [2*W-1:0] acc_r, acc_n, res, product, a_ext, b_ext;
   logic           neg_n;

   assign a_ext    = {{W{1'b0}}, a_r};
   assign b_ext    = {{W{1'b0}}, b_r};
   assign busy     = (state != IDLE);
   assign mul_load = take && (op == OP_MUL);

`ifdef ARITH_SAT_EN
   logic [2*W:0] acc_sum;
   logic         sat_hit;
   assign acc_sum = {1'b0, acc_r} + {{(W + 1){1'b0}}, a_r};
`else
   logic [2*W-1:0] acc_sum;
   assign acc_sum = acc_r + a_ext;
`endif

   seq_mul_core #(.W(W)) u_mul (
      .clk      (clk),
      .reset    (reset),
      .load     (mul_load),
      .A        (A),
      .B        (B),
      .product  (product),
      .mul_done (mul_done)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: if (start) begin
            take      = 1'b1;
            state_nxt = (op == OP_MUL) ? MUL : EXEC;
         end
         EXEC: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         MUL: if (mul_done) begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      res   = '0;
      neg_n = 1'b0;
      acc_n = acc_r;
`ifdef ARITH_SAT_EN
      sat_hit = 1'b0;
`endif
      case (op_r)
         OP_ADD: res = a_ext + b_ext;
         OP_SUB: begin
            res   = a_ext - b_ext;
            neg_n = (a_r < b_r);
         end
         OP_MUL: res = product;
         default: begin
            if (b_r[0]) begin
               acc_n = a_ext;
            end else begin
`ifdef ARITH_SAT_EN
               sat_hit = acc_sum[2*W];
               acc_n   = acc_sum[2*W] ? '1 : acc_sum[2*W-1:0];
`else
               acc_n = acc_sum;
`endif
            end
            res = acc_n;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         done  <= 1'b0;
         Y     <= '0;
         neg   <= 1'b0;
         acc_r <= '0;
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= OP_ADD;
`ifdef ARITH_SAT_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= finish;
         if (take) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= op;
         end
         if (finish) begin
            Y   <= res;
            neg <= neg_n;
            if (op_r == OP_ACC) begin
               acc_r <= acc_n;
`ifdef ARITH_SAT_EN
               if (b_r[0])       ovf <= 1'b0;
               else if (sat_hit) ovf <= 1'b1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_param_arith_seq.sv
// Scoreboard bench for param_arith_seq: directed scenarios then randomized ops vs. an arithmetic model.
module tb_param_arith_seq;

   localparam int W  = 3;
   localparam int YW = 2 * W;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [1:0]    op = 2'b00;
   logic          start = 1'b0;
   logic          busy, done, neg;
   logic [YW-1:0] Y;
`ifdef ARITH_SAT_EN
   logic          ovf;
`endif

   param_arith_seq #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .op    (op),
      .start (start),
      .busy  (busy),
      .done  (done),
      .Y     (Y),
      .neg   (neg)
`ifdef ARITH_SAT_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int y;
      bit neg;
      bit ovf;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   int   checks = 0;
   int   failures = 0;
   int   ref_acc = 0;
   bit   ref_ovf = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Reference computed from plain integer arithmetic
   task automatic model(input int o, input int a, input int b, output exp_t e);
      int full;
      full  = 1 << YW;
      e.neg = 1'b0;
      e.y   = 0;
      case (o)
         0: e.y = a + b;
         1: begin
            e.y   = (a - b + full) % full;
            e.neg = (a < b);
         end
         2: e.y = a * b;
         default: begin
            if (b % 2 == 1) begin
               ref_acc = a;
               ref_ovf = 1'b0;
            end else begin
               ref_acc = ref_acc + a;
               if (ref_acc > full - 1) begin
`ifdef ARITH_SAT_EN
                  ref_acc = full - 1;
                  ref_ovf = 1'b1;
`else
                  ref_acc = ref_acc % full;
`endif
               end
            end
            e.y = ref_acc;
         end
      endcase
      e.ovf = ref_ovf;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", busy, 0);
   endtask

   task automatic issue(input int o, input int a, input int b, input bit push);
      exp_t e;
      wait_idle();
      A     = W'(a);
      B     = W'(b);
      op    = 2'(o);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", busy, 1);
      if (push) begin
         model(o, a, b, e);
         e.cyc = cyc + ((o == 2) ? W : 1);
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      if (reset && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            got = sb.pop_front();
            check("Y", Y, got.y);
            check("neg", neg, got.neg);
            check("latency", cyc, got.cyc);
`ifdef ARITH_SAT_EN
            check("ovf", ovf, got.ovf);
`endif
         end
      end
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check("reset_Y", Y, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);

      issue(0, 2, 1, 1);
      issue(1, 5, 3, 1);
      issue(1, 3, 6, 1);

      // start pulsed while the multiply is running must be ignored
      issue(2, 7, 2, 1);
      @(negedge clk);
      A = 3'd1; B = 3'd1; op = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("mul_hold_Y", Y, 14);

      // start held across the completion edge must be ignored
      issue(0, 2, 2, 1);
      A = 3'd3; B = 3'd3; op = 2'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;

      issue(3, 7, 1, 1);
      for (int i = 0; i < 8; i++) issue(3, 7, 0, 1);
      issue(3, 7, 0, 1);
      issue(1, 4, 4, 1);
      issue(3, 1, 0, 1);

      // reset during the 2nd cycle of a multiply aborts it
      issue(2, 7, 7, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      ref_acc = 0;
      ref_ovf = 1'b0;
      check("abort_Y", Y, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      issue(0, 1, 1, 1);

      issue(2, 7, 0, 1);
      issue(0, 7, 7, 1);
      issue(2, 7, 7, 1);
      issue(2, 0, 0, 1);
      issue(1, 0, 0, 1);
      issue(3, 0, 0, 1);

      for (int i = 0; i < 60; i++)
         issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain", sb.size(), 0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
